nibble_bus_responder: RTL and testbench

Memory-side responder for the 4-bit CPU's nibble bus. It holds a program store and a 16-nibble data RAM, answers fetch and load cycles with read data, and commits store cycles. It also gates the CPU's reset so a host can preload memory, then reports fetch count and protocol errors. It sits at the top level between the CPU's `uo_out`/`uio_*` pins and the host load port.

---
 rtl/nibble_bus_responder_pkg.sv | 17 +
 rtl/nibble_bus_responder_if.sv | 25 ++
 rtl/nibble_ram.sv | 23 ++
 rtl/nibble_bus_responder.sv | 139 +++++++++++++
 tb/tb_nibble_bus_responder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/nibble_bus_responder_pkg.sv
// Shared decode constants and FSM state type
// for the nibble bus responder.
package nibble_bus_pkg;

  localparam logic [3:0] CTL_LOAD  = 4'b0111;
  localparam logic [3:0] CTL_STORE = 4'b0011;

  localparam logic [1:0] PH_F1 = 2'b00;
  localparam logic [1:0] PH_F2 = 2'b01;
  localparam logic [1:0] PH_F3 = 2'b10;

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

endpackage

// File: rtl/nibble_bus_responder_if.sv
// CPU-side nibble bus: address/control/data out,
// read data back from the memory responder.
interface nibble_bus_if;
  logic [7:0] bus_addr;
  logic [3:0] bus_ctl;
  logic [3:0] bus_wdata;
  logic       bus_oe;
  logic [3:0] bus_rdata;

  modport master (
    output bus_addr,
    output bus_ctl,
    output bus_wdata,
    output bus_oe,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr,
    input  bus_ctl,
    input  bus_wdata,
    input  bus_oe,
    output bus_rdata
  );
endinterface

// File: rtl/nibble_ram.sv
// Nibble-wide RAM: asynchronous read,
// synchronous single-port write, no reset.
module nibble_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [3:0]    rdata
);

  logic [3:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nibble_bus_responder.sv
// Memory-side responder for the nibble bus:
// program store, data RAM, CPU reset gating.
module nibble_bus_responder
  import nibble_bus_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  nibble_bus_if.slave      bus,
  output logic             cpu_rst_n,
  input  logic             host_we,
  input  logic             host_sel,
  input  logic [11:0]      host_addr,
  input  logic [3:0]       host_wdata,
  input  logic             host_run,
  input  logic             host_stop,
  output logic             running,
  output logic [CNT_W-1:0] fetch_count,
  output logic             err
);

  localparam int IW  = $clog2(PROG_DEPTH);
  localparam int PAW = IW + 2;
  localparam logic [10:0] DEPTH_L = 11'(PROG_DEPTH);

  state_t state_q, state_d;

  logic [9:0] idx;
  logic [1:0] ph;
  logic       idx_ok;
  logic [9:0] host_idx;
  logic       host_ok;
  logic       start;

  logic [3:0] prog_rd, dram_rd, rdata;
  logic       err_set, bus_st, f3;

  logic           prog_we;
  logic           dram_we;
  logic [3:0]     dram_waddr;
  logic [3:0]     dram_wdata;

  assign idx      = {bus.bus_addr, bus.bus_ctl[3:2]};
  assign ph       = bus.bus_ctl[1:0];
  assign idx_ok   = {1'b0, idx} < DEPTH_L;
  assign host_idx = host_addr[11:2];
  assign host_ok  = ({1'b0, host_idx} < DEPTH_L)
                 && (host_addr[1:0] != 2'b11);
  assign start    = (state_q == ST_LOAD)
                 && host_run && !host_stop;

  // host owns both write ports in LOAD, the bus owns dram in RUN
  assign prog_we = (state_q == ST_LOAD)
                && host_we && !host_sel && host_ok;

  always_comb begin
    dram_we    = bus_st;
    dram_waddr = bus.bus_addr[3:0];
    dram_wdata = bus.bus_wdata;
    if (state_q == ST_LOAD) begin
      dram_we    = host_we && host_sel;
      dram_waddr = host_addr[3:0];
      dram_wdata = host_wdata;
    end
  end

  nibble_ram #(.DEPTH(PROG_DEPTH * 4)) u_prog (
    .clk   (clk),
    .we    (prog_we),
    .waddr (host_addr[PAW-1:0]),
    .wdata (host_wdata),
    .raddr ({idx[IW-1:0], ph}),
    .rdata (prog_rd)
  );

  nibble_ram #(.DEPTH(16)) u_dram (
    .clk   (clk),
    .we    (dram_we),
    .waddr (dram_waddr),
    .wdata (dram_wdata),
    .raddr (bus.bus_addr[3:0]),
    .rdata (dram_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rdata   = '0;
    err_set = 1'b0;
    bus_st  = 1'b0;
    f3      = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (host_run && !host_stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (host_stop) state_d = ST_LOAD;
        unique case (1'b1)
          (ph != 2'b11): begin
            f3 = (ph == PH_F3);
            if (idx_ok) rdata   = prog_rd;
            else        err_set = 1'b1;
          end
          (bus.bus_ctl == CTL_LOAD): rdata = dram_rd;
          (bus.bus_ctl == CTL_STORE): begin
            if (bus.bus_oe) bus_st  = 1'b1;
            else            err_set = 1'b1;
          end
          default: err_set = 1'b1;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
      err         <= 1'b0;
    end else if (start) begin
      fetch_count <= '0;
      err         <= 1'b0;
    end else begin
      if (f3 && (fetch_count != '1))
        fetch_count <= fetch_count + 1'b1;
      if (err_set) err <= 1'b1;
    end
  end

  assign running       = (state_q == ST_RUN);
  assign cpu_rst_n     = running;
  assign bus.bus_rdata = rdata;

endmodule

// File: tb/tb_nibble_bus_responder.sv
// Directed checks of the nibble bus responder:
// fetch, load/store, errors, host gating, reset.
module tb_nibble_bus_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_we = 1'b0;
  logic        host_sel = 1'b0;
  logic [11:0] host_addr = '0;
  logic [3:0]  host_wdata = '0;
  logic        host_run = 1'b0;
  logic        host_stop = 1'b0;
  logic        cpu_rst_n;
  logic        running;
  logic [15:0] fetch_count;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  nibble_bus_if bif ();

  nibble_bus_responder #(
    .PROG_DEPTH (16),
    .CNT_W      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bif.slave),
    .cpu_rst_n   (cpu_rst_n),
    .host_we     (host_we),
    .host_sel    (host_sel),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_run    (host_run),
    .host_stop   (host_stop),
    .running     (running),
    .fetch_count (fetch_count),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_drive(input logic [7:0] a,
                           input logic [3:0] c,
                           input logic [3:0] w,
                           input logic       oe);
    bif.bus_addr  = a;
    bif.bus_ctl   = c;
    bif.bus_wdata = w;
    bif.bus_oe    = oe;
    #1;
  endtask

  task automatic hwr(input logic sel,
                     input logic [11:0] a,
                     input logic [3:0] d);
    host_we    = 1'b1;
    host_sel   = sel;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_we    = 1'b0;
  endtask

  task automatic pulse_run();
    host_run = 1'b1;
    tick();
    host_run = 1'b0;
  endtask

  task automatic pulse_stop();
    host_stop = 1'b1;
    tick();
    host_stop = 1'b0;
  endtask

  initial begin
    bus_drive(8'h00, 4'h0, 4'h0, 1'b0);
    tick();
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_fetch_count", 32'(fetch_count), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", 32'(bif.bus_rdata), 0);
    rst = 1'b0;
    tick();

    hwr(1'b0, 12'h000, 4'hC);
    hwr(1'b0, 12'h001, 4'h9);
    hwr(1'b0, 12'h002, 4'h5);
    hwr(1'b0, 12'h003, 4'h7);
    hwr(1'b0, 12'h040, 4'h3);
    hwr(1'b1, 12'h007, 4'h2);

    bus_drive(8'h07, 4'b0111, 4'h0, 1'b0);
    chk("load_in_LOAD_rdata", 32'(bif.bus_rdata), 0);

    pulse_run();
    chk("run_running", 32'(running), 1);
    chk("run_cpu_rst_n", 32'(cpu_rst_n), 1);

    bus_drive(8'h00, 4'b0000, 4'h0, 1'b0);
    chk("fetch_ph0", 32'(bif.bus_rdata), 32'hC);
    tick();
    bus_drive(8'h00, 4'b0001, 4'h0, 1'b0);
    chk("fetch_ph1", 32'(bif.bus_rdata), 32'h9);
    tick();
    chk("fcnt_before_ph2", 32'(fetch_count), 0);
    bus_drive(8'h00, 4'b0010, 4'h0, 1'b0);
    chk("fetch_ph2", 32'(bif.bus_rdata), 32'h5);
    tick();
    chk("fcnt_after_ph2", 32'(fetch_count), 1);

    bus_drive(8'h07, 4'b0111, 4'h0, 1'b0);
    chk("load_preload", 32'(bif.bus_rdata), 32'h2);
    tick();

    bus_drive(8'h07, 4'b0011, 4'hA, 1'b1);
    chk("store_rdata", 32'(bif.bus_rdata), 0);
    tick();
    bus_drive(8'h07, 4'b0111, 4'h0, 1'b0);
    chk("load_after_store", 32'(bif.bus_rdata), 32'hA);
    chk("store_err", 32'(err), 0);
    tick();

    bus_drive(8'h07, 4'b0011, 4'h5, 1'b0);
    tick();
    chk("store_no_oe_err", 32'(err), 1);
    bus_drive(8'h07, 4'b0111, 4'h0, 1'b0);
    chk("store_no_oe_kept", 32'(bif.bus_rdata), 32'hA);
    tick();

    pulse_stop();
    chk("stop_running", 32'(running), 0);
    chk("stop_err_sticky", 32'(err), 1);
    pulse_run();
    chk("rerun_err_clr", 32'(err), 0);
    chk("rerun_fcnt_clr", 32'(fetch_count), 0);

    bus_drive(8'h04, 4'b0000, 4'h0, 1'b0);
    chk("oor_fetch_rdata", 32'(bif.bus_rdata), 0);
    tick();
    chk("oor_fetch_err", 32'(err), 1);

    pulse_stop();
    pulse_run();
    chk("rerun2_err_clr", 32'(err), 0);
    bus_drive(8'h00, 4'b1111, 4'h0, 1'b0);
    chk("illegal_rdata", 32'(bif.bus_rdata), 0);
    tick();
    chk("illegal_err", 32'(err), 1);

    bus_drive(8'h00, 4'b0001, 4'h0, 1'b0);
    hwr(1'b1, 12'h007, 4'h3);
    hwr(1'b0, 12'h000, 4'hF);
    bus_drive(8'h07, 4'b0111, 4'h0, 1'b0);
    chk("run_hwr_dram", 32'(bif.bus_rdata), 32'hA);
    bus_drive(8'h00, 4'b0000, 4'h0, 1'b0);
    chk("run_hwr_prog", 32'(bif.bus_rdata), 32'hC);

    bus_drive(8'h08, 4'b0011, 4'h6, 1'b1);
    host_stop = 1'b1;
    tick();
    host_stop = 1'b0;
    chk("stop_cpu_rst_n", 32'(cpu_rst_n), 0);
    bus_drive(8'h00, 4'b0001, 4'h0, 1'b0);

    host_run  = 1'b1;
    host_stop = 1'b1;
    tick();
    host_run  = 1'b0;
    host_stop = 1'b0;
    chk("run_stop_same", 32'(running), 0);

    pulse_run();
    bus_drive(8'h08, 4'b0111, 4'h0, 1'b0);
    chk("store_at_stop", 32'(bif.bus_rdata), 32'h6);
    bus_drive(8'h00, 4'b0010, 4'h0, 1'b0);
    chk("fetch_ph2_bad_write", 32'(bif.bus_rdata), 32'h5);
    tick();
    chk("fcnt_run3", 32'(fetch_count), 1);

    #2;
    rst = 1'b1;
    #1;
    chk("arst_cpu_rst_n", 32'(cpu_rst_n), 0);
    chk("arst_running", 32'(running), 0);
    chk("arst_fcnt", 32'(fetch_count), 0);
    rst = 1'b0;
    tick();
    pulse_run();
    bus_drive(8'h07, 4'b0111, 4'h0, 1'b0);
    chk("arst_dram_kept", 32'(bif.bus_rdata), 32'hA);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
